// File: rtl/dm_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data memory.
//   slave  : arbiter side (takes requests, drives acks, read data, memory controls)
//   master : environment side (requesters and the data memory model)
interface dm_arbiter_if;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 64;

  // requester A (processor)
  logic              req_a;
  logic              we_a;
  logic [ADDR_W-1:0] addr_a;
  logic [DATA_W-1:0] wdata_a;
  logic              ack_a;
  logic [DATA_W-1:0] rdata_a;

  // requester B (DMA / debug)
  logic              req_b;
  logic              we_b;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] wdata_b;
  logic              ack_b;
  logic [DATA_W-1:0] rdata_b;

  // data memory side
  logic [ADDR_W-1:0] direccion;
  logic [DATA_W-1:0] dataWrite;
  logic              enableWr;
  logic              bitAddress;
  logic [DATA_W-1:0] bus_dataRead;

  // current grant: 00 idle, 01 A, 10 B
  logic [1:0]        owner;

  modport slave (
    input  req_a, we_a, addr_a, wdata_a,
    input  req_b, we_b, addr_b, wdata_b,
    input  bus_dataRead,
    output ack_a, rdata_a, ack_b, rdata_b,
    output direccion, dataWrite, enableWr, bitAddress, owner
  );

  modport master (
    output req_a, we_a, addr_a, wdata_a,
    output req_b, we_b, addr_b, wdata_b,
    output bus_dataRead,
    input  ack_a, rdata_a, ack_b, rdata_b,
    input  direccion, dataWrite, enableWr, bitAddress, owner
  );
endinterface

// File: rtl/dm_arbiter.sv
// Round-robin arbiter giving two requesters single-cycle access to one data
// memory. A request sampled at edge N is presented to memory in cycle N+1 and
// acknowledged (with registered read data) in cycle N+2.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   port  : dm_arbiter_if.slave (requests, acks, read data, memory controls)
module dm_arbiter (
  input  logic         clk,
  input  logic         rst_n,
  dm_arbiter_if.slave  port
);
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SERV_A = 2'd1,
    SERV_B = 2'd2
  } state_t;

  state_t              state;
  logic                last_b;      // 1: B was served last, so A wins a tie
  logic [ADDR_W-1:0]   cmd_addr;
  logic [DATA_W-1:0]   cmd_wdata;
  logic                cmd_we;
  logic                mem_sel;
  logic [1:0]          owner_q;
  logic                ack_a_q;
  logic                ack_b_q;
  logic [DATA_W-1:0]   rdata_a_q;
  logic [DATA_W-1:0]   rdata_b_q;
  logic                grant_a_c;
  logic                grant_b_c;

  // Next grant; the port just served is ignored at the edge ending its access
  always_comb begin
    grant_a_c = 1'b0;
    grant_b_c = 1'b0;
    case (state)
      IDLE: begin
        grant_a_c = port.req_a & (~port.req_b | last_b);
        grant_b_c = port.req_b & ~(port.req_a & (~port.req_b | last_b));
      end
      SERV_A:  grant_b_c = port.req_b;
      SERV_B:  grant_a_c = port.req_a;
      default: begin
        grant_a_c = 1'b0;
        grant_b_c = 1'b0;
      end
    endcase
  end

  // State, command latch, ack pulse and read-data capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last_b    <= 1'b1;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      cmd_we    <= 1'b0;
      mem_sel   <= 1'b0;
      owner_q   <= 2'b00;
      ack_a_q   <= 1'b0;
      ack_b_q   <= 1'b0;
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else begin
      ack_a_q <= 1'b0;
      ack_b_q <= 1'b0;

      // Completion of the access presented during this cycle
      case (state)
        SERV_A: begin
          rdata_a_q <= port.bus_dataRead;
          ack_a_q   <= 1'b1;
          last_b    <= 1'b0;
        end
        SERV_B: begin
          rdata_b_q <= port.bus_dataRead;
          ack_b_q   <= 1'b1;
          last_b    <= 1'b1;
        end
        default: begin
          last_b <= last_b;
        end
      endcase

      // Start of the next access, or back to idle with the address held
      if (grant_a_c) begin
        state     <= SERV_A;
        owner_q   <= 2'b01;
        cmd_addr  <= port.addr_a;
        cmd_wdata <= port.wdata_a;
        cmd_we    <= port.we_a;
        mem_sel   <= 1'b1;
      end else if (grant_b_c) begin
        state     <= SERV_B;
        owner_q   <= 2'b10;
        cmd_addr  <= port.addr_b;
        cmd_wdata <= port.wdata_b;
        cmd_we    <= port.we_b;
        mem_sel   <= 1'b1;
      end else begin
        state     <= IDLE;
        owner_q   <= 2'b00;
        cmd_we    <= 1'b0;
        mem_sel   <= 1'b0;
      end
    end
  end

  assign port.direccion  = cmd_addr;
  assign port.dataWrite  = cmd_wdata;
  assign port.enableWr   = cmd_we;
  assign port.bitAddress = mem_sel;
  assign port.owner      = owner_q;
  assign port.ack_a      = ack_a_q;
  assign port.ack_b      = ack_b_q;
  assign port.rdata_a    = rdata_a_q;
  assign port.rdata_b    = rdata_b_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed scenarios followed by random two-port traffic
// checked against a transaction-level memory/fairness model.
module tb_dm_arbiter;
  logic clk;
  logic rst_n;

  dm_arbiter_if bus_if ();

  dm_arbiter u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .port  (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory environment: synchronous write, combinational read
  logic [63:0] mem [4096];
  always @(posedge clk)
    if (bus_if.enableWr && bus_if.bitAddress) mem[bus_if.direccion] <= bus_if.dataWrite;
  assign bus_if.bus_dataRead = mem[bus_if.direccion];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle_ports();
    bus_if.req_a = 1'b0; bus_if.we_a = 1'b0; bus_if.addr_a = '0; bus_if.wdata_a = '0;
    bus_if.req_b = 1'b0; bus_if.we_b = 1'b0; bus_if.addr_b = '0; bus_if.wdata_b = '0;
  endtask

  task automatic do_reset();
    idle_ports();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Single access on one port from idle; returns rdata seen in the ack cycle
  task automatic single_access(input bit port_b, input bit we, input logic [11:0] addr,
                               input logic [63:0] wd, input string tag,
                               output logic [63:0] rd);
    if (!port_b) begin
      bus_if.req_a = 1'b1; bus_if.we_a = we; bus_if.addr_a = addr; bus_if.wdata_a = wd;
    end else begin
      bus_if.req_b = 1'b1; bus_if.we_b = we; bus_if.addr_b = addr; bus_if.wdata_b = wd;
    end
    @(negedge clk);
    check({tag, "_c1_we"},   64'(bus_if.enableWr), 64'(we));
    check({tag, "_c1_sel"},  64'(bus_if.bitAddress), 64'd1);
    check({tag, "_c1_addr"}, 64'(bus_if.direccion), 64'(addr));
    check({tag, "_c1_own"},  64'(bus_if.owner), port_b ? 64'd2 : 64'd1);
    if (we) check({tag, "_c1_wd"}, bus_if.dataWrite, wd);
    @(negedge clk);
    check({tag, "_c2_ack"}, 64'({bus_if.ack_b, bus_if.ack_a}), port_b ? 64'd2 : 64'd1);
    rd = port_b ? bus_if.rdata_b : bus_if.rdata_a;
    idle_ports();
    @(negedge clk);
    check({tag, "_c3_ack"}, 64'({bus_if.ack_b, bus_if.ack_a}), 64'd0);
    check({tag, "_c3_we"},  64'(bus_if.enableWr), 64'd0);
    check({tag, "_c3_own"}, 64'(bus_if.owner), 64'd0);
  endtask

  // Random-phase requester state and reference model
  logic        pend   [2];
  int          wait_c [2];
  int          others [2];
  logic [11:0] c_addr [2];
  logic        c_we   [2];
  logic [63:0] c_wd   [2];
  logic [63:0] ref_mem [int];

  task automatic drive_ports();
    bus_if.req_a = pend[0]; bus_if.we_a = c_we[0]; bus_if.addr_a = c_addr[0]; bus_if.wdata_a = c_wd[0];
    bus_if.req_b = pend[1]; bus_if.we_b = c_we[1]; bus_if.addr_b = c_addr[1]; bus_if.wdata_b = c_wd[1];
  endtask

  initial begin
    logic [63:0] rd;
    logic [63:0] old;
    logic [1:0]  prev_own;
    logic [1:0]  ack;
    logic [63:0] rdv [2];
    int          na, nb, lat, p;

    rst_n = 1'b1;
    idle_ports();
    do_reset();

    // Reset values
    check("rst_own",   64'(bus_if.owner), 64'd0);
    check("rst_we",    64'(bus_if.enableWr), 64'd0);
    check("rst_sel",   64'(bus_if.bitAddress), 64'd0);
    check("rst_addr",  64'(bus_if.direccion), 64'd0);
    check("rst_wd",    bus_if.dataWrite, 64'd0);
    check("rst_ack",   64'({bus_if.ack_b, bus_if.ack_a}), 64'd0);
    check("rst_rda",   bus_if.rdata_a, 64'd0);
    check("rst_rdb",   bus_if.rdata_b, 64'd0);

    // Single write on A, then read-back on B
    single_access(1'b0, 1'b1, 12'h010, 64'hDEAD_BEEF_0000_0001, "wr010", rd);
    check("wr010_mem", mem[12'h010], 64'hDEAD_BEEF_0000_0001);
    single_access(1'b1, 1'b0, 12'h010, 64'd0, "rd010", rd);
    check("rd010_data", rd, 64'hDEAD_BEEF_0000_0001);

    // Simultaneous requests right after reset: A first, B back-to-back
    do_reset();
    bus_if.req_a = 1'b1; bus_if.addr_a = 12'h010;
    bus_if.req_b = 1'b1; bus_if.addr_b = 12'h010;
    @(negedge clk);
    check("sim_own1", 64'(bus_if.owner), 64'd1);
    @(negedge clk);
    check("sim_acka", 64'({bus_if.ack_b, bus_if.ack_a}), 64'd1);
    check("sim_own2", 64'(bus_if.owner), 64'd2);
    bus_if.req_a = 1'b0;
    @(negedge clk);
    check("sim_ackb", 64'({bus_if.ack_b, bus_if.ack_a}), 64'd2);
    check("sim_rdb",  bus_if.rdata_b, 64'hDEAD_BEEF_0000_0001);
    bus_if.req_b = 1'b0;
    @(negedge clk);
    check("sim_idle", 64'(bus_if.owner), 64'd0);

    // Continuous contention for 20 cycles
    bus_if.req_a = 1'b1; bus_if.req_b = 1'b1;
    na = 0; nb = 0; prev_own = 2'b00;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus_if.ack_a) na++;
      if (bus_if.ack_b) nb++;
      check("cont_busy", 64'(bus_if.owner == 2'b00), 64'd0);
      check("cont_alt",  64'(bus_if.owner == prev_own), 64'd0);
      prev_own = bus_if.owner;
    end
    check("cont_na", 64'(na >= 9 && na <= 11), 64'd1);
    check("cont_nb", 64'(nb >= 9 && nb <= 11), 64'd1);
    idle_ports();
    repeat (3) @(negedge clk);

    // Boundary address: top word does not alias word 0
    single_access(1'b0, 1'b1, 12'hFFF, 64'h0123_4567_89AB_CDEF, "wrFFF", rd);
    single_access(1'b1, 1'b1, 12'h000, 64'hFEDC_BA98_7654_3210, "wr000", rd);
    single_access(1'b1, 1'b0, 12'hFFF, 64'd0, "rdFFF", rd);
    check("rdFFF_data", rd, 64'h0123_4567_89AB_CDEF);
    single_access(1'b0, 1'b0, 12'h000, 64'd0, "rd000", rd);
    check("rd000_data", rd, 64'hFEDC_BA98_7654_3210);

    // Reset in the middle of a write on A
    old = mem[12'h020];
    bus_if.req_a = 1'b1; bus_if.we_a = 1'b1; bus_if.addr_a = 12'h020;
    bus_if.wdata_a = 64'hA5A5_A5A5_5A5A_5A5A ^ old;
    @(negedge clk);
    check("rstw_we", 64'(bus_if.enableWr), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rstw_own",  64'(bus_if.owner), 64'd0);
    check("rstw_we0",  64'(bus_if.enableWr), 64'd0);
    check("rstw_sel",  64'(bus_if.bitAddress), 64'd0);
    check("rstw_addr", 64'(bus_if.direccion), 64'd0);
    check("rstw_wd",   bus_if.dataWrite, 64'd0);
    check("rstw_rda",  bus_if.rdata_a, 64'd0);
    check("rstw_rdb",  bus_if.rdata_b, 64'd0);
    idle_ports();
    @(negedge clk);
    check("rstw_mem",  mem[12'h020], old);
    check("rstw_ack",  64'(bus_if.ack_a), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rstw_ack2", 64'(bus_if.ack_a), 64'd0);
    check("rstw_mem2", mem[12'h020], old);

    // Random two-port traffic against the transaction model
    for (int i = 0; i < 2; i++) begin
      pend[i] = 1'b0; wait_c[i] = 0; others[i] = 0;
      c_addr[i] = '0; c_we[i] = 1'b0; c_wd[i] = '0;
    end
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      ack    = {bus_if.ack_b, bus_if.ack_a};
      rdv[0] = bus_if.rdata_a;
      rdv[1] = bus_if.rdata_b;

      check("r_ack_excl", 64'(ack == 2'b11), 64'd0);
      check("r_we_idle",  64'(bus_if.enableWr && bus_if.owner == 2'b00), 64'd0);
      check("r_sel_own",  64'(bus_if.bitAddress), 64'(bus_if.owner != 2'b00));
      check("r_own_ok",   64'(bus_if.owner == 2'b11), 64'd0);

      if (bus_if.owner == 2'b01 || bus_if.owner == 2'b10) begin
        p = (bus_if.owner == 2'b01) ? 0 : 1;
        check("r_serv_pend", 64'(pend[p]), 64'd1);
        check("r_serv_addr", 64'(bus_if.direccion), 64'(c_addr[p]));
        check("r_serv_we",   64'(bus_if.enableWr), 64'(c_we[p]));
        if (c_we[p]) check("r_serv_wd", bus_if.dataWrite, c_wd[p]);
      end

      for (int q = 0; q < 2; q++) begin
        if (ack[q]) begin
          check("r_ack_pend", 64'(pend[q]), 64'd1);
          if (pend[q]) begin
            lat = wait_c[q] + 1;
            check("r_latency", 64'(lat >= 2 && lat <= 3), 64'd1);
            check("r_fair",    64'(others[q] <= 1), 64'd1);
            if (ref_mem.exists(int'(c_addr[q]))) check("r_rdata", rdv[q], ref_mem[int'(c_addr[q])]);
            if (c_we[q]) ref_mem[int'(c_addr[q])] = c_wd[q];
            pend[q] = 1'b0;
            if (pend[1-q]) others[1-q]++;
          end
        end
      end

      for (int q = 0; q < 2; q++) begin
        if (pend[q]) begin
          wait_c[q]++;
          if (wait_c[q] >= 3) begin
            check("r_timeout", 64'd1, 64'd0);
            pend[q] = 1'b0;
          end
        end else if ($urandom_range(1, 0) == 1) begin
          pend[q]   = 1'b1;
          wait_c[q] = 0;
          others[q] = 0;
          c_addr[q] = ($urandom_range(3, 0) == 0) ? 12'hFFF : 12'($urandom_range(15, 0));
          c_we[q]   = 1'($urandom_range(1, 0));
          c_wd[q]   = {$urandom, $urandom};
        end
      end
      drive_ports();
    end

    idle_ports();
    repeat (4) @(negedge clk);
    check("end_idle", 64'(bus_if.owner), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 SHALL have: clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have: rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have: req_a, req_b  input  1 each  access request from port A (processor) and port B (DMA/debug), held until ack.
REQ-004 SHALL have: we_a, we_b  input  1 each  1 = write, 0 = read, valid while req.
REQ-005 SHALL have: addr_a, addr_b  input  12 each  memory word address, valid while req.
REQ-006 SHALL have: wdata_a, wdata_b  input  64 each  write data, valid while req.
REQ-007 SHALL have: ack_a, ack_b  output  1 each  one-cycle completion pulse.
REQ-008 SHALL have: rdata_a, rdata_b  output  64 each  registered read data, valid from ack and held until the next ack on the same port.
REQ-009 SHALL have: direccion  output  12, dataWrite  output  64, enableWr  output  1, bitAddress  output  1  drive the data memory.
REQ-010 SHALL have: bus_dataRead  input  64  combinational read data from the data memory.
REQ-011 SHALL have: owner  output  2  00 idle, 01 A being served, 10 B being served.

Function
REQ-012 SHALL implement FSM states IDLE, SERV_A, SERV_B.
REQ-013 In IDLE, SHALL sample req_a/req_b each edge; one requester -> its SERV state; both -> port not in last_served; none -> stay IDLE.
REQ-014 On entering SERV_x, SHALL latch addr_x, we_x, wdata_x into command registers at that same edge.
REQ-015 In SERV_x, SHALL drive direccion/dataWrite from the command registers, bitAddress = 1, enableWr = latched we; in IDLE SHALL drive enableWr = 0, bitAddress = 0, direccion/dataWrite holding last values.
REQ-016 At the edge ending SERV_x, SHALL register rdata_x <= bus_dataRead (also for writes), set ack_x = 1 for exactly the next cycle, and set last_served = x.
REQ-017 Latency: req sampled at edge N -> memory access in cycle N+1 -> ack and rdata valid in cycle N+2.
REQ-018 At the edge ending SERV_x, the served port's req SHALL be ignored. If the other port's req = 1, SHALL go directly to its SERV state and latch its command; otherwise SHALL go to IDLE.
REQ-019 A req high during a cycle in which that port's ack is high SHALL be treated as a new request; requesters drop req in the ack cycle if done.
REQ-020 Round-robin SHALL guarantee neither port waits more than one other access while continuously requesting.
REQ-021 ack_a and ack_b SHALL never be high in the same cycle; enableWr SHALL never be 1 outside SERV states.
REQ-022 owner SHALL equal 01/10 exactly in SERV_A/SERV_B, 00 in IDLE.

Reset
REQ-023 rst_n low SHALL immediately force IDLE, ack_a = ack_b = 0, enableWr = 0, bitAddress = 0, owner = 00, direccion = 0, dataWrite = 0, rdata_a = rdata_b = 0, last_served = B (A wins first tie).
REQ-024 Reset during SERV_x SHALL abort the access with no memory write and no ack; the requester re-issues after reset.
REQ-025 After rst_n rises, the first edge SHALL sample requests normally.

Verification
REQ-026 Single write: req_a = 1, we_a = 1, addr_a = 12'h010, wdata_a = 64'hDEAD_BEEF_0000_0001 -> cycle +1: enableWr = 1, bitAddress = 1, direccion = 010; cycle +2: ack_a = 1 for one cycle; memory word 010 holds the value.
REQ-027 Read-back: req_b = 1, we_b = 0, addr_b = 12'h010 -> ack_b two cycles later, rdata_b = 64'hDEAD_BEEF_0000_0001, enableWr stays 0.
REQ-028 Simultaneous after reset: req_a = req_b = 1 in the same cycle -> SERV_A then SERV_B back-to-back with no IDLE between; ack_a then ack_b on consecutive cycles.
REQ-029 Continuous contention: both req held high for 20 cycles -> owner alternates 01/10; A and B each get 10 ±1 acks; no port is served twice in a row while the other requests.
REQ-030 Reset mid-write: assert rst_n = 0 during SERV_A with we_a = 1, addr 12'h020 -> no write to 020, ack_a never pulses, all outputs at reset values.
REQ-031 Boundary address: write addr 12'hFFF then read 12'hFFF -> data returned intact with no wrap to 000.
